compare_sequencer: RTL and testbench

COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

---
 rtl/compare_sequencer.sv | 145 ++++++++++++++
 tb/tb_compare_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/compare_sequencer.sv
// compare_sequencer
//   Accepts two 4-bit operands as consecutive nibbles on data_in (x first,
//   then y). The operation selected with the x nibble is applied to the pair.
//   The result is then held until downstream consumes it.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   synchronous active-low reset
//   data_in[3:0]  in   operand nibble (x, then y)
//   data_valid    in   data_in valid this cycle
//   data_ready    out  block accepts data_in this cycle (IDLE / LOAD_Y)
//   op_sel[1:0]   in   00 EQ, 01 GT, 10 LT, 11 MAX; sampled with x
//   x[3:0]        out  latched x operand
//   y[3:0]        out  latched y operand
//   result[3:0]   out  operation result
//   result_valid  out  result held valid (HOLD)
//   result_ready  in   downstream consumes result
//   busy          out  state != IDLE
//   pair_count    out  completed result handshakes, wraps at 256
module compare_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [1:0] op_sel,
    output logic [3:0] x,
    output logic [3:0] y,
    output logic [3:0] result,
    output logic       result_valid,
    input  logic       result_ready,
    output logic       busy,
    output logic [7:0] pair_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD_Y  = 2'd1,
        S_COMPARE = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_x;
    logic [3:0] r_y;
    logic [1:0] r_op;
    logic [3:0] r_result;
    logic [7:0] r_pair_count;
    logic [3:0] w_cmp;
    logic       w_accept_x;
    logic       w_accept_y;
    logic       w_consume;

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next       = r_state;
        data_ready   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        w_accept_x   = 1'b0;
        w_accept_y   = 1'b0;
        w_consume    = 1'b0;
        case (r_state)
            S_IDLE: begin
                data_ready = 1'b1;
                busy       = 1'b0;
                if (data_valid) begin
                    w_accept_x = 1'b1;
                    w_next     = S_LOAD_Y;
                end
            end
            S_LOAD_Y: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    w_accept_y = 1'b1;
                    w_next     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                w_next = S_HOLD;
            end
            S_HOLD: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    w_consume = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Unsigned 4-bit operation on the latched operands
    always_comb begin
        w_cmp = '0;
        case (r_op)
            2'b00:   w_cmp = {3'b000, (r_x == r_y)};
            2'b01:   w_cmp = {3'b000, (r_x > r_y)};
            2'b10:   w_cmp = {3'b000, (r_x < r_y)};
            default: w_cmp = (r_y > r_x) ? r_y : r_x;
        endcase
    end

    // Datapath registers; result only updates in COMPARE so it is stable
    // throughout HOLD regardless of input activity.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_op         <= '0;
            r_result     <= '0;
            r_pair_count <= '0;
        end else begin
            if (w_accept_x) begin
                r_x  <= data_in;
                r_op <= op_sel;
            end
            if (w_accept_y) begin
                r_y <= data_in;
            end
            if (r_state == S_COMPARE) begin
                r_result <= w_cmp;
            end
            if (w_consume) begin
                r_pair_count <= r_pair_count + 8'd1;
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign result     = r_result;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_compare_sequencer.sv
// tb_compare_sequencer
//   Directed bench for compare_sequencer. Inputs are driven and outputs
//   sampled 1 time unit after each rising clock edge.
module tb_compare_sequencer;

    logic       clk;
    logic       reset_n;
    logic [3:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] op_sel;
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] result;
    logic       result_valid;
    logic       result_ready;
    logic       busy;
    logic [7:0] pair_count;

    int unsigned n_cmp;
    int unsigned n_err;
    logic [7:0]  exp_cnt;

    compare_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .op_sel       (op_sel),
        .x            (x),
        .y            (y),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .pair_count   (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full pair with checks along the way; expects to start in IDLE.
    task automatic do_pair(input string tag, input logic [1:0] op,
                           input logic [3:0] xv, input logic [3:0] yv,
                           input logic [3:0] exp_res);
        data_valid = 1'b1; data_in = xv; op_sel = op;
        step();                              // x accepted -> LOAD_Y
        data_in = yv; op_sel = ~op;
        step();                              // y accepted -> COMPARE
        data_valid = 1'b0;
        chk({tag, " cmp_rv"}, {7'd0, result_valid}, 8'h00);
        chk({tag, " cmp_rdy"}, {7'd0, data_ready}, 8'h00);
        step();                              // -> HOLD
        chk({tag, " rv"}, {7'd0, result_valid}, 8'h01);
        chk({tag, " res"}, {4'd0, result}, {4'd0, exp_res});
        chk({tag, " x"}, {4'd0, x}, {4'd0, xv});
        chk({tag, " y"}, {4'd0, y}, {4'd0, yv});
        result_ready = 1'b1;
        step();                              // consumed -> IDLE
        result_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk({tag, " rv_clr"}, {7'd0, result_valid}, 8'h00);
        chk({tag, " cnt"}, pair_count, exp_cnt);
    endtask

    // Unchecked pair used for the wrap run.
    task automatic fast_pair();
        data_valid = 1'b1; data_in = 4'h1; op_sel = 2'b00;
        step();
        data_in = 4'h2;
        step();
        data_valid = 1'b0;
        step();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; exp_cnt = 8'h00;
        reset_n = 1'b0; data_in = 4'h0; data_valid = 1'b0; op_sel = 2'b00;
        result_ready = 1'b0;
        step(); step();
        reset_n = 1'b1;
        chk("rst x", {4'd0, x}, 8'h00);
        chk("rst y", {4'd0, y}, 8'h00);
        chk("rst res", {4'd0, result}, 8'h00);
        chk("rst rv", {7'd0, result_valid}, 8'h00);
        chk("rst cnt", pair_count, 8'h00);
        chk("rst rdy", {7'd0, data_ready}, 8'h01);
        chk("rst busy", {7'd0, busy}, 8'h00);

        // Basic MAX with result_ready held high throughout
        result_ready = 1'b1;
        data_valid = 1'b1; data_in = 4'h3; op_sel = 2'b11;
        step();
        chk("max busy", {7'd0, busy}, 8'h01);
        data_in = 4'h9;
        step();                              // y accept edge
        data_valid = 1'b0;
        chk("max rv0", {7'd0, result_valid}, 8'h00);
        step();                              // 2nd edge after y accept
        chk("max rv1", {7'd0, result_valid}, 8'h01);
        chk("max res", {4'd0, result}, 8'h09);
        step();
        result_ready = 1'b0;
        exp_cnt = 8'h01;
        chk("max cnt", pair_count, exp_cnt);
        chk("max idle", {7'd0, busy}, 8'h00);

        // Boundary pairs for every op
        do_pair("eq ff", 2'b00, 4'hF, 4'hF, 4'h1);
        do_pair("eq 0f", 2'b00, 4'h0, 4'hF, 4'h0);
        do_pair("eq f0", 2'b00, 4'hF, 4'h0, 4'h0);
        do_pair("gt ff", 2'b01, 4'hF, 4'hF, 4'h0);
        do_pair("gt 0f", 2'b01, 4'h0, 4'hF, 4'h0);
        do_pair("gt f0", 2'b01, 4'hF, 4'h0, 4'h1);
        do_pair("lt ff", 2'b10, 4'hF, 4'hF, 4'h0);
        do_pair("lt 0f", 2'b10, 4'h0, 4'hF, 4'h1);
        do_pair("lt f0", 2'b10, 4'hF, 4'h0, 4'h0);
        do_pair("mx ff", 2'b11, 4'hF, 4'hF, 4'hF);
        do_pair("mx 0f", 2'b11, 4'h0, 4'hF, 4'hF);
        do_pair("mx f0", 2'b11, 4'hF, 4'h0, 4'hF);
        do_pair("mx 5a", 2'b11, 4'h5, 4'hA, 4'hA);

        // Backpressure: HOLD for 5 cycles with data_valid toggling data
        data_valid = 1'b1; data_in = 4'hA; op_sel = 2'b01;
        step();
        data_in = 4'h4;
        step();
        step();                              // now HOLD
        for (int i = 0; i < 5; i++) begin
            data_in = 4'(i + 11);
            step();
            chk("bp rv", {7'd0, result_valid}, 8'h01);
            chk("bp res", {4'd0, result}, 8'h01);
            chk("bp x", {4'd0, x}, 8'h0A);
            chk("bp y", {4'd0, y}, 8'h04);
            chk("bp rdy", {7'd0, data_ready}, 8'h00);
        end
        data_valid = 1'b0; result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("bp busy", {7'd0, busy}, 8'h00);
        chk("bp cnt", pair_count, exp_cnt);
        chk("bp x2", {4'd0, x}, 8'h0A);

        // Idle gap between x and y
        data_valid = 1'b1; data_in = 4'h7; op_sel = 2'b00;
        step();
        data_valid = 1'b0; data_in = 4'h2;
        step(); step(); step();
        chk("gap busy", {7'd0, busy}, 8'h01);
        chk("gap rdy", {7'd0, data_ready}, 8'h01);
        chk("gap rv", {7'd0, result_valid}, 8'h00);
        data_valid = 1'b1; data_in = 4'h7; op_sel = 2'b11;
        step();
        data_valid = 1'b0;
        step();
        chk("gap res", {4'd0, result}, 8'h01);
        chk("gap rv1", {7'd0, result_valid}, 8'h01);
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
        exp_cnt = exp_cnt + 8'd1;
        chk("gap cnt", pair_count, exp_cnt);

        // Reset during LOAD_Y
        data_valid = 1'b1; data_in = 4'hC; op_sel = 2'b11;
        step();
        data_valid = 1'b0; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_cnt = 8'h00;
        chk("rly busy", {7'd0, busy}, 8'h00);
        chk("rly x", {4'd0, x}, 8'h00);
        chk("rly cnt", pair_count, 8'h00);
        chk("rly rdy", {7'd0, data_ready}, 8'h01);
        do_pair("rly nxt", 2'b01, 4'h5, 4'h2, 4'h1);

        // Reset during HOLD
        data_valid = 1'b1; data_in = 4'h8; op_sel = 2'b11;
        step();
        data_in = 4'h6;
        step();
        data_valid = 1'b0;
        step();
        chk("rh pre", {7'd0, result_valid}, 8'h01);
        reset_n = 1'b0; result_ready = 1'b1;
        step();
        reset_n = 1'b1; result_ready = 1'b0;
        exp_cnt = 8'h00;
        chk("rh rv", {7'd0, result_valid}, 8'h00);
        chk("rh res", {4'd0, result}, 8'h00);
        chk("rh x", {4'd0, x}, 8'h00);
        chk("rh y", {4'd0, y}, 8'h00);
        chk("rh cnt", pair_count, 8'h00);
        chk("rh busy", {7'd0, busy}, 8'h00);
        do_pair("rh nxt", 2'b10, 4'h3, 4'hE, 4'h1);

        // Counter wrap: from 1, 255 more pairs reach 256 -> 0
        for (int i = 0; i < 255; i++) begin
            fast_pair();
        end
        chk("wrap 256", pair_count, 8'h00);
        chk("wrap exp", pair_count, exp_cnt);
        fast_pair();
        chk("wrap 257", pair_count, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
